// File: rtl/register_file_if.sv
// Register-file access bundle: one write port and two asynchronous read ports.
// The master drives addresses and write data; the slave returns read data.
interface register_file_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             RegWrite;
    logic [AW-1:0]    WriteReg;
    logic [WIDTH-1:0] WriteData;
    logic [AW-1:0]    ReadReg1;
    logic [AW-1:0]    ReadReg2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: register 0 hard-wired to zero, write-first bypass
// on both read ports, asynchronous active-high clear of all storage.
module register_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input logic             clk,
    input logic             rst,
    register_file_if.slave  bus
);
    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;

    // Writes to register 0 are dropped here, so they neither store nor bypass.
    assign wr_en = bus.RegWrite && (bus.WriteReg != '0);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: this memory is reset on purpose: all registers must read 0 right after
    // rst rises, which forces flops rather than a RAM macro here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    // NOTE: outputs get defaults first so no path through this block infers a latch.
    always_comb begin
        bus.ReadData1 = '0;
        bus.ReadData2 = '0;
        if (!rst) begin
            if (bus.ReadReg1 != '0) begin
                bus.ReadData1 = (wr_en && bus.ReadReg1 == bus.WriteReg)
                              ? bus.WriteData : regs[bus.ReadReg1];
            end
            if (bus.ReadReg2 != '0) begin
                bus.ReadData2 = (wr_en && bus.ReadReg2 == bus.WriteReg)
                              ? bus.WriteData : regs[bus.ReadReg2];
            end
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a directed vector table for single-cycle
// behaviour plus hand-written sequences for reset timing and a full sweep.
module tb_register_file;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    register_file_if #(.WIDTH(32), .DEPTH(32)) bus ();

    register_file #(.WIDTH(32), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.RegWrite  = we;
        bus.WriteReg  = wa;
        bus.WriteData = wd;
        bus.ReadReg1  = ra1;
        bus.ReadReg2  = ra2;
    endtask

    initial begin
        // Expected values are the combinational outputs seen before the vector's edge.
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h0};
        vecs[1]  = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd4,  32'h12345678, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h12345678, 32'h12345678};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd3,  32'h0,        32'h12345678};
        vecs[5]  = '{1'b1, 5'd7,  32'h1,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h1,        32'h1};
        vecs[7]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd7,  32'h0,        32'hA5A5A5A5};
        vecs[9]  = '{1'b1, 5'd9,  32'h10,       5'd9,  5'd0,  32'h10,       32'h0};
        vecs[10] = '{1'b0, 5'd9,  32'h55,       5'd9,  5'd9,  32'h10,       32'h10};
        vecs[11] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'hFFFFFFFF, 32'h10};

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        @(negedge clk);
        #1;
        check("reset_rd1", bus.ReadData1, 32'h0);
        check("reset_rd2", bus.ReadData2, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            #1;
            check($sformatf("vec%0d_rd1", i), bus.ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), bus.ReadData2, vecs[i].e2);
        end

        // Asynchronous reset between edges clears a stored value at once.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        #1;
        check("r5_before_rst", bus.ReadData1, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        check("r5_async_clear", bus.ReadData1, 32'h0);
        check("r9_async_clear", bus.ReadData2, 32'h0);

        // Writes and bypass are suppressed while reset is held across an edge.
        drive(1'b1, 5'd5, 32'h77777777, 5'd5, 5'd5);
        #1;
        check("rst_no_bypass", bus.ReadData1, 32'h0);
        @(posedge clk);
        #1;
        check("rst_no_write_held", bus.ReadData2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        #1;
        check("r5_after_rst", bus.ReadData1, 32'h0);
        check("r31_after_rst", bus.ReadData2, 32'h0);

        // The first edge after reset release accepts a write.
        drive(1'b1, 5'd6, 32'h0000CAFE, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd0);
        #1;
        check("first_write_after_rst", bus.ReadData1, 32'h0000CAFE);

        // A write whose edge coincides with reset assertion is lost.
        drive(1'b1, 5'd8, 32'h00001234, 5'd8, 5'd6);
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd6);
        #1;
        check("coincident_write_lost", bus.ReadData1, 32'h0);
        check("coincident_r6_cleared", bus.ReadData2, 32'h0);

        // Full sweep: Rk = k * 0x01010101, then read pairs (k, 32-k).
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(k), 32'(k) * 32'h01010101, 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check("sweep_r0_rd1", bus.ReadData1, 32'h0);
        check("sweep_r0_rd2", bus.ReadData2, 32'h0);
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(k), 5'(32 - k));
            #1;
            check($sformatf("sweep_rd1_r%0d", k), bus.ReadData1, 32'(k) * 32'h01010101);
            check($sformatf("sweep_rd2_r%0d", 32 - k), bus.ReadData2, 32'(32 - k) * 32'h01010101);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; address width is log2(DEPTH) = 5.
REQ-003 SHALL have port clk, input, 1, single clock; all writes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port RegWrite, input, 1, write enable sampled on rising clk.
REQ-006 SHALL have port WriteReg, input, 5, destination register address.
REQ-007 SHALL have port WriteData, input, WIDTH, write data (driven by the upstream 2:1 writeback select).
REQ-008 SHALL have port ReadReg1, input, 5, read port 1 address.
REQ-009 SHALL have port ReadReg2, input, 5, read port 2 address.
REQ-010 SHALL have port ReadData1, output, WIDTH, read port 1 data.
REQ-011 SHALL have port ReadData2, output, WIDTH, read port 2 data.

Function
REQ-012 SHALL hold DEPTH registers of WIDTH bits each.
REQ-013 SHALL write WriteData into register WriteReg on a rising clk edge when RegWrite=1 and WriteReg!=0.
REQ-014 SHALL ignore writes to register 0; register 0 SHALL always read 32'd0.
REQ-015 SHALL leave storage unchanged on any edge with RegWrite=0.
REQ-016 SHALL drive ReadData1/ReadData2 combinationally from the addressed register, with zero-cycle read latency.
REQ-017 SHALL bypass when RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg: ReadDataN SHALL equal WriteData in the same cycle (write-first).
REQ-018 SHALL apply the bypass independently to both read ports; both ports may address the same register at once.
REQ-019 SHALL update stored contents only at the rising edge; the bypass SHALL NOT alter storage.
REQ-020 SHALL NOT bypass for WriteReg=0; a read of register 0 SHALL return 0 even when a write to register 0 is pending.
REQ-021 SHALL produce no X on ReadData outputs after reset for any in-range address.

Reset
REQ-022 SHALL clear all registers to 0 immediately when rst rises, without waiting for a clk edge.
REQ-023 SHALL hold all registers at 0 while rst=1 and ignore RegWrite during reset.
REQ-024 SHALL drive ReadData1=ReadData2=0 while rst=1; the bypass SHALL be suppressed during reset.
REQ-025 SHALL accept its first write on the first rising clk edge after rst falls.
REQ-026 SHALL lose a write whose edge coincides with reset assertion; the register reads 0.

Verification
REQ-027 Reset: write R5=0xDEADBEEF, then pulse rst between clk edges -> ReadData1(R5)=0 immediately, before the next edge.
REQ-028 Basic write/read: RegWrite=1, WriteReg=3, WriteData=0x12345678 at an edge; next cycle RegWrite=0, ReadReg1=3, ReadReg2=3 -> both outputs 0x12345678.
REQ-029 R0 protection: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, ReadReg1=0 -> ReadData1=0 before and after the edge.
REQ-030 Bypass: R7 holds 0x1; in the same cycle RegWrite=1, WriteReg=7, WriteData=0xA5A5A5A5, ReadReg2=7 -> ReadData2=0xA5A5A5A5 before the edge, and R7=0xA5A5A5A5 after it.
REQ-031 Disabled write: RegWrite=0, WriteReg=9, WriteData=0x55 with R9=0x10 -> R9 stays 0x10 and no bypass occurs.
REQ-032 Full sweep: write Rk=k*0x01010101 for k=1..31, then read every pair (k, 32-k) -> correct values on both ports, and R0=0.
